sd_sector_responder: RTL and testbench

- Responder end of the sector-buffer protocol the core uses for backup-RAM save/load (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Serves requests from an on-chip or DDR-backed virtual disk of SECTORS x 512-byte sectors (256 x 16-bit words per sector). Lets save/load run without HPS involvement in sim and standalone builds.
- Streams words into the requester's buffer on read and pulls them out of it on write. Talks to the backing store over a simple word req/ready port.

---
 rtl/sd_sector_responder_if.sv | 33 +++
 rtl/sd_sector_responder.sv | 116 +++++++++++
 tb/tb_sd_sector_responder.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_responder_if.sv
// Sector-buffer port (sd_*) plus the word port to the backing store (mem_*).
// slave = responder view; master = requester-and-memory view.
interface sd_sector_responder_if #(
    parameter int SEC_W = 4
);
    logic [31:0]      sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;
    logic [7:0]       sd_buff_addr;
    logic [15:0]      sd_buff_dout;
    logic             sd_buff_wr;
    logic [15:0]      sd_buff_din;

    logic [SEC_W+7:0] mem_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic [15:0]      mem_wdata;
    logic [15:0]      mem_rdata;
    logic             mem_ready;

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/sd_sector_responder.sv
// Responder for sector-buffer read/write requests, backed by a word-wide store
// of 2**SEC_W sectors x 256 words; out-of-range sectors read as fill and drop writes.
module sd_sector_responder #(
    parameter int SEC_W     = 4,
    parameter bit ZERO_FILL = 1'b1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    sd_sector_responder_if.slave bus
);
    localparam logic [15:0] FILL = ZERO_FILL ? 16'h0000 : 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lba_q,   lba_d;
    logic [7:0]  word_q,  word_d;
    logic [15:0] dout_q,  dout_d;
    logic [15:0] wdata_q, wdata_d;

    logic in_range;
    logic last_word;

    // The whole 32-bit sector number is range-checked, not just the low bits.
    assign in_range  = (lba_q[31:SEC_W] == '0);
    assign last_word = (word_q == 8'hFF);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lba_q   <= '0;
            word_q  <= '0;
            dout_q  <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            lba_q   <= lba_d;
            word_q  <= word_d;
            dout_q  <= dout_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        lba_d   = lba_q;
        word_d  = word_q;
        dout_d  = dout_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.sd_rd || bus.sd_wr) begin
                    lba_d   = bus.sd_lba;
                    word_d  = '0;
                    state_d = bus.sd_rd ? RD_REQ : WR_ADDR;
                end
            end
            RD_REQ: begin
                if (!in_range) begin
                    dout_d  = FILL;
                    state_d = RD_PUT;
                end else if (bus.mem_ready) begin
                    dout_d  = bus.mem_rdata;
                    state_d = RD_PUT;
                end
            end
            RD_PUT: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    word_d  = word_q + 8'd1;
                    state_d = RD_REQ;
                end
            end
            WR_ADDR: state_d = WR_CAP;
            WR_CAP: begin
                wdata_d = bus.sd_buff_din;
                if (in_range) begin
                    state_d = WR_MEM;
                end else if (last_word) begin
                    state_d = DONE;
                end else begin
                    word_d  = word_q + 8'd1;
                    state_d = WR_ADDR;
                end
            end
            WR_MEM: begin
                if (bus.mem_ready) begin
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        word_d  = word_q + 8'd1;
                        state_d = WR_ADDR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack covers DONE too, so it falls on the edge that returns to IDLE.
    assign bus.sd_ack       = (state_q != IDLE);
    assign bus.sd_buff_addr = word_q;
    assign bus.sd_buff_dout = dout_q;
    assign bus.sd_buff_wr   = (state_q == RD_PUT);
    assign bus.mem_addr     = {lba_q[SEC_W-1:0], word_q};
    assign bus.mem_rd       = (state_q == RD_REQ) && in_range;
    assign bus.mem_wr       = (state_q == WR_MEM);
    assign bus.mem_wdata    = wdata_q;
endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: behavioural memory, requester buffer and
// per-sector expectations computed from sector contents and range rules.
module tb_sd_sector_responder;
  localparam int SEC_W   = 4;
  localparam int SECTORS = 1 << SEC_W;
  localparam int WORDS   = 256;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } strobe_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  sd_sector_responder_if #(.SEC_W(SEC_W)) bus ();

  sd_sector_responder #(.SEC_W(SEC_W), .ZERO_FILL(1'b1)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem     [SECTORS*WORDS];
  logic [15:0] mem_ref [SECTORS*WORDS];
  logic [15:0] wbuf    [WORDS];
  strobe_t     strobes [$];

  bit zero_wait = 1'b1;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, addr_moves = 0;
  int cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic ack_prev = 1'b0;

  bit busy = 1'b0;
  int wait_cnt = 0;
  logic [SEC_W+7:0] req_addr = '0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Word store: answers a request one cycle after it is first seen (plus optional wait).
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(posedge clk_sys); #1;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'($urandom);
        busy = 1'b0;
      end else if (busy) begin
        if (wait_cnt == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = 16'hDEAD;
          if (bus.mem_rd) begin
            bus.mem_rdata = mem[bus.mem_addr];
            rd_cnt++;
          end
          if (bus.mem_wr) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wr_cnt++;
          end
        end else begin
          wait_cnt--;
        end
      end else if (bus.mem_rd || bus.mem_wr) begin
        busy     = 1'b1;
        req_addr = bus.mem_addr;
        wait_cnt = zero_wait ? 0 : int'($urandom_range(0, 3));
      end
    end
  end

  // Requester buffer: data appears one cycle after the address is presented.
  initial begin
    logic [7:0] a;
    bus.sd_buff_din = 16'h0;
    forever begin
      @(negedge clk_sys);
      a = bus.sd_buff_addr;
      @(posedge clk_sys); #1;
      bus.sd_buff_din = wbuf[a];
    end
  end

  // Passive monitor: strobes, ack edges, store-port rules.
  always @(negedge clk_sys) begin
    strobe_t st;
    if (bus.sd_buff_wr === 1'b1) begin
      st.addr = bus.sd_buff_addr;
      st.data = bus.sd_buff_dout;
      strobes.push_back(st);
    end
    if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) both_cnt++;
    if ((bus.mem_rd || bus.mem_wr) && busy && bus.mem_addr !== req_addr) addr_moves++;
    if (bus.sd_ack === 1'b1 && ack_prev !== 1'b1) rise_cyc = cyc;
    if (bus.sd_ack === 1'b0 && ack_prev === 1'b1) fall_cyc = cyc;
    ack_prev = bus.sd_ack;
  end

  function automatic logic [15:0] exp_word(input logic [31:0] lba, input int n);
    if (lba >= 32'(SECTORS)) return 16'h0000;
    return mem_ref[int'(lba) * WORDS + n];
  endfunction

  function automatic int bad_strobes(input logic [31:0] lba, input int base);
    int bad = 0;
    strobe_t s;
    if (strobes.size() < base + WORDS) return WORDS;
    for (int i = 0; i < WORDS; i++) begin
      s = strobes[base + i];
      if (s.addr !== 8'(i) || s.data !== exp_word(lba, i)) bad++;
    end
    return bad;
  endfunction

  function automatic int bad_mem();
    int bad = 0;
    for (int i = 0; i < SECTORS*WORDS; i++) if (mem[i] !== mem_ref[i]) bad++;
    return bad;
  endfunction

  function automatic void ref_write(input logic [31:0] lba);
    if (lba < 32'(SECTORS))
      for (int n = 0; n < WORDS; n++) mem_ref[int'(lba) * WORDS + n] = wbuf[n];
  endfunction

  task automatic wait_ack(input logic level, input int budget, input string name, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (bus.sd_ack !== level) begin
      @(posedge clk_sys); #1;
      n++;
      if (n > budget) begin
        ok = 1'b0;
        checks++;
        errors++;
        $display("FAIL %s: sd_ack=%b after %0d cycles, required %b", name, bus.sd_ack, n, level);
        break;
      end
    end
  endtask

  task automatic transfer(input bit rd, input bit wr, input logic [31:0] lba, input string name);
    bit ok;
    @(posedge clk_sys); #1;
    bus.sd_lba = lba;
    bus.sd_rd  = rd;
    bus.sd_wr  = wr;
    wait_ack(1'b1, 10, name, ok);
    bus.sd_rd  = 1'b0;
    bus.sd_wr  = 1'b0;
    bus.sd_lba = $urandom;
    if (ok) wait_ack(1'b0, 5000, name, ok);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if ({bus.sd_ack, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ack,buff_wr,mem_rd,mem_wr=%b, expected 0000",
               {bus.sd_ack, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr});
    end
    checks++;
    if (bus.sd_buff_addr !== 8'h00 || bus.sd_buff_dout !== 16'h0000 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: addr=%h dout=%h mem_addr=%h wdata=%h, expected all 0",
               bus.sd_buff_addr, bus.sd_buff_dout, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (bus.sd_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: sd_ack=%b, expected 0", bus.sd_ack);
    end
  endtask

  task automatic test_read_sector();
    zero_wait = 1'b1;
    for (int n = 0; n < WORDS; n++) begin
      mem[3*WORDS + n]     = 16'h3000 + 16'(n);
      mem_ref[3*WORDS + n] = 16'h3000 + 16'(n);
    end
    strobes.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    transfer(1'b1, 1'b0, 32'd3, "read_lba3");
    @(negedge clk_sys); #1;
    checks++;
    if (strobes.size() !== WORDS) begin
      errors++;
      $display("FAIL read_lba3 strobes: got %0d, expected %0d", strobes.size(), WORDS);
    end
    checks++;
    if (bad_strobes(32'd3, 0) !== 0) begin
      errors++;
      $display("FAIL read_lba3 data: %0d bad strobes, expected 0", bad_strobes(32'd3, 0));
    end
    checks++;
    if (fall_cyc - rise_cyc !== 769) begin
      errors++;
      $display("FAIL read_lba3 ack_len: got %0d cycles, expected 769", fall_cyc - rise_cyc);
    end
    checks++;
    if (rd_cnt !== WORDS || wr_cnt !== 0) begin
      errors++;
      $display("FAIL read_lba3 mem_ops: rd=%0d wr=%0d, expected rd=256 wr=0", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_write_sector();
    zero_wait = 1'b1;
    for (int n = 0; n < WORDS; n++) wbuf[n] = ~16'(n);
    ref_write(32'd5);
    strobes.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    transfer(1'b0, 1'b1, 32'd5, "write_lba5");
    @(negedge clk_sys); #1;
    checks++;
    if (bad_mem() !== 0) begin
      errors++;
      $display("FAIL write_lba5 mem: %0d wrong words, expected 0 (mem[0x500]=%h want %h)",
               bad_mem(), mem[12'h500], mem_ref[12'h500]);
    end
    checks++;
    if (wr_cnt !== WORDS || rd_cnt !== 0 || strobes.size() !== 0) begin
      errors++;
      $display("FAIL write_lba5 ops: wr=%0d rd=%0d strobes=%0d, expected 256/0/0",
               wr_cnt, rd_cnt, strobes.size());
    end
    checks++;
    if (fall_cyc - rise_cyc !== 1025) begin
      errors++;
      $display("FAIL write_lba5 ack_len: got %0d cycles, expected 1025", fall_cyc - rise_cyc);
    end
  endtask

  task automatic test_out_of_range();
    zero_wait = 1'b1;
    strobes.delete();
    rd_cnt = 0;
    transfer(1'b1, 1'b0, 32'd20, "read_oor");
    @(negedge clk_sys); #1;
    checks++;
    if (strobes.size() !== WORDS || bad_strobes(32'd20, 0) !== 0) begin
      errors++;
      $display("FAIL read_oor data: strobes=%0d bad=%0d, expected 256 strobes of 0000",
               strobes.size(), bad_strobes(32'd20, 0));
    end
    checks++;
    if (rd_cnt !== 0 || fall_cyc - rise_cyc !== 513) begin
      errors++;
      $display("FAIL read_oor ops: mem_rd=%0d ack_len=%0d, expected 0 and 513",
               rd_cnt, fall_cyc - rise_cyc);
    end
    for (int n = 0; n < WORDS; n++) wbuf[n] = 16'($urandom);
    wr_cnt = 0;
    transfer(1'b0, 1'b1, 32'h0001_0002, "write_oor");
    @(negedge clk_sys); #1;
    checks++;
    if (wr_cnt !== 0 || bad_mem() !== 0) begin
      errors++;
      $display("FAIL write_oor: mem_wr=%0d changed_words=%0d, expected 0 and 0", wr_cnt, bad_mem());
    end
    checks++;
    if (fall_cyc - rise_cyc !== 513) begin
      errors++;
      $display("FAIL write_oor ack_len: got %0d, expected 513", fall_cyc - rise_cyc);
    end
  endtask

  task automatic test_rd_wr_same_cycle();
    bit ok;
    int gap;
    zero_wait = 1'b1;
    for (int n = 0; n < WORDS; n++) wbuf[n] = 16'($urandom);
    strobes.delete();
    wr_cnt = 0;
    @(posedge clk_sys); #1;
    bus.sd_lba = 32'd1;
    bus.sd_rd  = 1'b1;
    bus.sd_wr  = 1'b1;
    wait_ack(1'b1, 10, "both_rise", ok);
    bus.sd_rd  = 1'b0;
    bus.sd_lba = 32'd1;
    if (ok) wait_ack(1'b0, 5000, "both_read_fall", ok);
    @(negedge clk_sys); #1;
    checks++;
    if (strobes.size() !== WORDS || bad_strobes(32'd1, 0) !== 0 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL both_read_first: strobes=%0d bad=%0d mem_wr=%0d, expected 256/0/0",
               strobes.size(), bad_strobes(32'd1, 0), wr_cnt);
    end
    wait_ack(1'b1, 10, "both_write_rise", ok);
    @(negedge clk_sys); #1;
    gap = rise_cyc - fall_cyc;
    checks++;
    if (gap !== 1) begin
      errors++;
      $display("FAIL both_idle_gap: ack low for %0d cycles, expected 1", gap);
    end
    bus.sd_wr = 1'b0;
    if (ok) wait_ack(1'b0, 5000, "both_write_fall", ok);
    ref_write(32'd1);
    @(negedge clk_sys); #1;
    checks++;
    if (bad_mem() !== 0 || wr_cnt !== WORDS || strobes.size() !== WORDS) begin
      errors++;
      $display("FAIL both_write_after: bad_words=%0d mem_wr=%0d strobes=%0d, expected 0/256/256",
               bad_mem(), wr_cnt, strobes.size());
    end
  endtask

  task automatic test_sector_loop();
    bit ok;
    int bad = 0;
    zero_wait = 1'b0;
    strobes.delete();
    rd_cnt = 0;
    @(posedge clk_sys); #1;
    for (int s = 0; s < SECTORS; s++) begin
      bus.sd_lba = 32'(s);
      bus.sd_rd  = 1'b1;
      wait_ack(1'b1, 10, "loop_rise", ok);
      bus.sd_rd  = 1'b0;
      if (!ok) break;
      wait_ack(1'b0, 5000, "loop_fall", ok);
      if (!ok) break;
    end
    @(negedge clk_sys); #1;
    for (int s = 0; s < SECTORS; s++) bad += bad_strobes(32'(s), s * WORDS);
    checks++;
    if (strobes.size() !== SECTORS * WORDS) begin
      errors++;
      $display("FAIL loop strobes: got %0d, expected %0d", strobes.size(), SECTORS * WORDS);
    end
    checks++;
    if (bad !== 0 || rd_cnt !== SECTORS * WORDS) begin
      errors++;
      $display("FAIL loop data: bad=%0d mem_rd=%0d, expected 0 and %0d", bad, rd_cnt, SECTORS * WORDS);
    end
  endtask

  task automatic test_random_mix();
    logic [31:0] lba;
    bit          is_rd;
    for (int t = 0; t < 6; t++) begin
      zero_wait = 1'($urandom_range(0, 1));
      is_rd     = 1'($urandom_range(0, 1));
      lba       = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, SECTORS - 1));
      for (int n = 0; n < WORDS; n++) wbuf[n] = 16'($urandom);
      strobes.delete();
      rd_cnt = 0;
      wr_cnt = 0;
      transfer(is_rd, !is_rd, lba, "mix");
      if (!is_rd) ref_write(lba);
      @(negedge clk_sys); #1;
      checks++;
      if (is_rd ? (strobes.size() !== WORDS || bad_strobes(lba, 0) !== 0) : (bad_mem() !== 0)) begin
        errors++;
        $display("FAIL mix%0d %s lba=%h: strobes=%0d bad_strobes=%0d bad_mem=%0d, expected clean",
                 t, is_rd ? "rd" : "wr", lba, strobes.size(), bad_strobes(lba, 0), bad_mem());
      end
      checks++;
      if ((is_rd ? rd_cnt : wr_cnt) !== ((lba < 32'(SECTORS)) ? WORDS : 0)) begin
        errors++;
        $display("FAIL mix%0d ops lba=%h: got %0d mem ops, expected %0d", t, lba,
                 is_rd ? rd_cnt : wr_cnt, (lba < 32'(SECTORS)) ? WORDS : 0);
      end
    end
  endtask

  task automatic test_reset_midway();
    bit ok;
    int n = 0;
    zero_wait = 1'b1;
    @(posedge clk_sys); #1;
    bus.sd_lba = 32'd4;
    bus.sd_rd  = 1'b1;
    wait_ack(1'b1, 10, "rst_mid_rise", ok);
    bus.sd_rd  = 1'b0;
    while (!(bus.sd_buff_addr === 8'd100 && bus.mem_rd === 1'b1) && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL rst_mid_reach: word 100 request not seen within %0d cycles", n);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.sd_ack, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr} !== 4'b0000 ||
        bus.sd_buff_addr !== 8'h00 || bus.sd_buff_dout !== 16'h0000 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_outputs: ack=%b mem_rd=%b addr=%h dout=%h mem_addr=%h, expected all 0",
               bus.sd_ack, bus.mem_rd, bus.sd_buff_addr, bus.sd_buff_dout, bus.mem_addr);
    end
    #1;
    reset_n = 1'b1;
    strobes.delete();
    rd_cnt = 0;
    repeat (6) @(posedge clk_sys);
    #1;
    checks++;
    if (bus.sd_ack !== 1'b0 || strobes.size() !== 0 || bus.mem_rd !== 1'b0 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL rst_mid_late_ready: ack=%b strobes=%0d mem_rd=%b reads=%0d, expected idle",
               bus.sd_ack, strobes.size(), bus.mem_rd, rd_cnt);
    end
    transfer(1'b1, 1'b0, 32'd2, "rst_mid_reread");
    @(negedge clk_sys); #1;
    checks++;
    if (strobes.size() !== WORDS || bad_strobes(32'd2, 0) !== 0 || fall_cyc - rise_cyc !== 769) begin
      errors++;
      $display("FAIL rst_mid_reread: strobes=%0d bad=%0d ack_len=%0d, expected 256/0/769",
               strobes.size(), bad_strobes(32'd2, 0), fall_cyc - rise_cyc);
    end
  endtask

  task automatic test_mem_port_rules();
    checks++;
    if (both_cnt !== 0 || addr_moves !== 0) begin
      errors++;
      $display("FAIL mem_port_rules: rd&wr together %0d cycles, addr moved %0d cycles, expected 0/0",
               both_cnt, addr_moves);
    end
  endtask

  initial begin
    bus.sd_lba = 32'h0;
    bus.sd_rd  = 1'b0;
    bus.sd_wr  = 1'b0;
    for (int i = 0; i < SECTORS*WORDS; i++) begin
      mem[i]     = 16'($urandom);
      mem_ref[i] = mem[i];
    end
    for (int n = 0; n < WORDS; n++) wbuf[n] = 16'($urandom);

    test_reset();
    test_read_sector();
    test_write_sector();
    test_out_of_range();
    test_rd_wr_same_cycle();
    test_sector_loop();
    test_random_mix();
    test_reset_midway();
    test_mem_port_rules();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
